shift_reg_ctrl: RTL and testbench

Sequencer for the 4-bit serial-in shift register. It accepts a parallel word over a valid/ready handshake, clears the register, and clocks the word in serially, one bit per cycle. It then reads the register's parallel output back, compares it against the expected value, and reports completion. It sits between a parallel producer and the shift register, driving the register's serial data and shift enable.

---
 rtl/shift_reg_ctrl.sv | 157 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - sequencer that serially loads a shift register and verifies it by read-back
module shift_reg_ctrl #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             abort,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_data,
    output logic             sr_shift,
    output logic             sr_clr,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [WIDTH-1:0] word_out,
    output logic             aborted
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_CAPTURE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] word_out_q;
    logic [WIDTH-1:0] expected;
    logic             load_ready_q;
    logic             busy_q;
    logic             sr_data_q;
    logic             sr_shift_q;
    logic             sr_clr_q;
    logic             done_q;
    logic             match_q;
    logic             aborted_q;
    logic             last_bit;

    // Serial order: bit k of the sequence, MSB-first unless LSB_FIRST is set.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
        if (LSB_FIRST != 0) begin
            return w[k];
        end
        return w[CW'(WIDTH-1) - k];
    endfunction

    // The first bit shifted in ends up in the MSB, so LSB-first order reads back reversed.
    always_comb begin
        expected = hold_q;
        if (LSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                expected[i] = hold_q[WIDTH-1-i];
            end
        end
    end

    assign last_bit = (cnt_q == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            word_out_q   <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            sr_data_q    <= 1'b0;
            sr_shift_q   <= 1'b0;
            sr_clr_q     <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        hold_q       <= load_data;
                        cnt_q        <= '0;
                        state_q      <= ST_CLEAR;
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        sr_clr_q     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    sr_clr_q <= 1'b0;
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        aborted_q    <= 1'b1;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        state_q    <= ST_SHIFT;
                        sr_shift_q <= 1'b1;
                        sr_data_q  <= pick_bit(hold_q, '0);
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        aborted_q    <= 1'b1;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        sr_shift_q   <= 1'b0;
                        sr_data_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (last_bit) begin
                            state_q    <= ST_CAPTURE;
                            sr_shift_q <= 1'b0;
                            sr_data_q  <= 1'b0;
                        end else begin
                            sr_data_q <= pick_bit(hold_q, cnt_q + CW'(1));
                        end
                    end
                end
                ST_CAPTURE: begin
                    word_out_q   <= sr_q;
                    match_q      <= (sr_q == expected);
                    done_q       <= 1'b1;
                    state_q      <= ST_IDLE;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    sr_shift_q   <= 1'b0;
                    sr_clr_q     <= 1'b0;
                    sr_data_q    <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign sr_data    = sr_data_q;
    assign sr_shift   = sr_shift_q;
    assign sr_clr     = sr_clr_q;
    assign done       = done_q;
    assign match      = match_q;
    assign word_out   = word_out_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - randomized bench for shift_reg_ctrl with both serial orders and a behavioural register
module tb_shift_reg_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic         lv   [2];
    logic [W-1:0] ld   [2];
    logic         ab   [2];
    logic         flt  [2];
    logic         sd   [2];
    logic         ss   [2];
    logic         sc   [2];
    logic         lr   [2];
    logic         bz   [2];
    logic         dn   [2];
    logic         mt   [2];
    logic         abd  [2];
    logic [W-1:0] wo   [2];
    logic [W-1:0] last_word [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [W-1:0] reg_q;
        logic [W-1:0] reg_out;

        // Shift register under control; a fault forces the read-back of bit 2 low.
        always_ff @(posedge clk) begin
            if (sc[g]) begin
                reg_q <= '0;
            end else if (ss[g]) begin
                reg_q <= {reg_q[W-2:0], sd[g]};
            end
        end
        assign reg_out = flt[g] ? (reg_q & 4'b1011) : reg_q;

        shift_reg_ctrl #(.WIDTH(W), .LSB_FIRST(g)) u_dut (
            .clk        (clk),
            .clr        (clr),
            .load_valid (lv[g]),
            .load_data  (ld[g]),
            .load_ready (lr[g]),
            .abort      (ab[g]),
            .sr_q       (reg_out),
            .sr_data    (sd[g]),
            .sr_shift   (ss[g]),
            .sr_clr     (sc[g]),
            .busy       (bz[g]),
            .done       (dn[g]),
            .match      (mt[g]),
            .word_out   (wo[g]),
            .aborted    (abd[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input int g);
        chk("rst_ready", lr[g], 1);
        chk("rst_busy", bz[g], 0);
        chk("rst_sdata", sd[g], 0);
        chk("rst_shift", ss[g], 0);
        chk("rst_clr", sc[g], 0);
        chk("rst_done", dn[g], 0);
        chk("rst_match", mt[g], 0);
        chk("rst_word", wo[g], 0);
        chk("rst_aborted", abd[g], 0);
    endtask

    // abort_cyc: 0 = with the handshake (ignored), 1..5 = CLEAR/SHIFT (cancels),
    // 6 = during CAPTURE (ignored), anything else = no abort.
    task automatic run_word(input int g, input logic [W-1:0] data, input int abort_cyc, input logic fault);
        logic [W-1:0] ideal;
        logic [W-1:0] expw;
        logic         bitv;
        for (int i = 0; i < W; i++) begin
            ideal[i] = (g == 1) ? data[W-1-i] : data[i];
        end
        expw   = fault ? (ideal & 4'b1011) : ideal;
        flt[g] = fault;
        chk("ready_c0", lr[g], 1);
        lv[g] = 1'b1;
        ld[g] = data;
        ab[g] = (abort_cyc == 0);
        step();
        lv[g] = 1'b0;
        ld[g] = W'($urandom);
        ab[g] = (abort_cyc == 1);
        chk("clr_c1", sc[g], 1);
        chk("busy_c1", bz[g], 1);
        chk("shift_c1", ss[g], 0);
        chk("ready_c1", lr[g], 0);
        chk("done_c1", dn[g], 0);
        chk("aborted_c1", abd[g], 0);
        for (int c = 2; c <= 6; c++) begin
            step();
            ab[g] = (abort_cyc == c);
            if (abort_cyc >= 1 && abort_cyc <= 5 && abort_cyc == c - 1) begin
                ab[g] = 1'b0;
                chk("abort_pulse", abd[g], 1);
                chk("abort_shift", ss[g], 0);
                chk("abort_busy", bz[g], 0);
                chk("abort_ready", lr[g], 1);
                chk("abort_done", dn[g], 0);
                chk("abort_word", wo[g], last_word[g]);
                return;
            end
            if (c <= 5) begin
                bitv = (g == 1) ? data[c-2] : data[W-1-(c-2)];
                chk("shift_on", ss[g], 1);
                chk("shift_clr", sc[g], 0);
                chk("shift_bit", sd[g], bitv);
                chk("shift_busy", bz[g], 1);
            end else begin
                chk("cap_shift", ss[g], 0);
                chk("cap_busy", bz[g], 1);
                chk("cap_done", dn[g], 0);
            end
        end
        step();
        ab[g] = 1'b0;
        chk("done_c7", dn[g], 1);
        chk("match_c7", mt[g], (expw == ideal));
        chk("word_c7", wo[g], expw);
        chk("ready_c7", lr[g], 1);
        chk("busy_c7", bz[g], 0);
        chk("aborted_c7", abd[g], 0);
        last_word[g] = expw;
    endtask

    initial begin
        clr = 1'b0;
        for (int g = 0; g < 2; g++) begin
            lv[g] = 1'b0;
            ld[g] = '0;
            ab[g] = 1'b0;
            flt[g] = 1'b0;
            last_word[g] = '0;
        end
        repeat (3) step();
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        clr = 1'b1;
        step();

        run_word(0, 4'b1011, -1, 1'b0);
        run_word(1, 4'b0001, -1, 1'b0);
        run_word(0, 4'b1111, -1, 1'b1);
        run_word(0, 4'b1011, 3, 1'b0);
        run_word(0, 4'b0110, -1, 1'b0);
        run_word(0, 4'hA, -1, 1'b0);
        run_word(0, 4'h5, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int g;
            int ac;
            g  = int'($urandom_range(0, 1));
            ac = int'($urandom_range(0, 12));
            if (ac > 6) ac = -1;
            if ($urandom_range(0, 2) == 0) begin
                step();
                chk("gap_ready", lr[g], 1);
                chk("gap_done", dn[g], 0);
            end
            run_word(g, W'($urandom), ac, ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of SHIFT.
        flt[0] = 1'b0;
        lv[0] = 1'b1;
        ld[0] = 4'b1101;
        step();
        lv[0] = 1'b0;
        step();
        step();
        chk("pre_rst_shift", ss[0], 1);
        #2;
        clr = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        step();
        clr = 1'b1;
        last_word[0] = '0;
        last_word[1] = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("post_rst_done", dn[0], 0);
            chk("post_rst_aborted", abd[0], 0);
            chk("post_rst_ready", lr[0], 1);
        end
        run_word(0, 4'b1001, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
